// File: rtl/lcd_cmd_issuer.sv
// Queues host commands in a circular FIFO and issues them one at a time to an LCD controller.
// Optional macro LCD_SHIFT_FILTER_EN drops Shift commands that would move the operation point out of 1..7.
module lcd_cmd_issuer #(
    parameter int FIFO_DEPTH = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] in_cmd,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [3:0] lcd_cmd,
    output logic       lcd_cmd_valid,
    input  logic       lcd_busy,
    input  logic       lcd_done,
    output logic [7:0] issued_cnt,
    output logic       fin
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(FIFO_DEPTH);

    // Handshake: a push happens on a rising edge where in_valid=1 and in_ready=1;
    // lcd_cmd_valid is a single-cycle strobe, never raised while lcd_busy=1.
    typedef enum logic [2:0] {
        S_BOOT, S_IDLE, S_ISSUE, S_GUARD, S_WAIT, S_FINISH
    } state_t;

    state_t state;
    state_t state_next;

    logic [3:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [3:0]    head;
    logic          push;
    logic          pop;
    logic          load;
    logic          shift_blocked;
    logic          last_write;

    assign head          = mem[rd_ptr];
    assign in_ready      = (count < DEPTH_C) && (state != S_FINISH);
    assign push          = in_valid && in_ready;
    // Every pop consumes the head; only legal commands are loaded for issue.
    assign pop           = (state == S_IDLE) && (count != '0) && !lcd_busy;
    assign load          = pop && (head < 4'd12) && !shift_blocked;
    assign lcd_cmd_valid = (state == S_ISSUE) && !lcd_busy;

`ifdef LCD_SHIFT_FILTER_EN
    logic [2:0] pos_x;
    logic [2:0] pos_y;

    always_comb begin
        shift_blocked = 1'b0;
        case (head)
            4'd1:    shift_blocked = (pos_y == 3'd1);
            4'd2:    shift_blocked = (pos_y == 3'd7);
            4'd3:    shift_blocked = (pos_x == 3'd1);
            4'd4:    shift_blocked = (pos_x == 3'd7);
            default: shift_blocked = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pos_x <= 3'd4;
            pos_y <= 3'd4;
        end else if (load) begin
            case (head)
                4'd1:    pos_y <= pos_y - 3'd1;
                4'd2:    pos_y <= pos_y + 3'd1;
                4'd3:    pos_x <= pos_x - 3'd1;
                4'd4:    pos_x <= pos_x + 3'd1;
                default: ;
            endcase
        end
    end
`else
    assign shift_blocked = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= in_cmd;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= S_BOOT;
            lcd_cmd    <= 4'd0;
            last_write <= 1'b0;
            issued_cnt <= 8'd0;
            fin        <= 1'b0;
        end else begin
            state <= state_next;
            if (load) begin
                lcd_cmd    <= head;
                last_write <= (head == 4'd0);
            end
            if (lcd_cmd_valid && issued_cnt != 8'hFF) begin
                issued_cnt <= issued_cnt + 8'd1;
            end
            if (state_next == S_FINISH) begin
                fin <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_BOOT:   if (!lcd_busy) state_next = S_IDLE;
            S_IDLE:   if (load) state_next = S_ISSUE;
            S_ISSUE:  if (!lcd_busy) state_next = S_GUARD;
            S_GUARD:  state_next = S_WAIT;
            // A Write ends operation: wait for the image write-out, not for busy.
            S_WAIT: begin
                if (last_write) begin
                    if (lcd_done) state_next = S_FINISH;
                end else if (!lcd_busy) begin
                    state_next = S_IDLE;
                end
            end
            S_FINISH: state_next = S_FINISH;
            default:  state_next = S_BOOT;
        endcase
    end
endmodule

// File: tb/tb_lcd_cmd_issuer.sv
// Directed bench for lcd_cmd_issuer: stimulus pushes expected issues into exp_q, a monitor pops on each strobe.
module tb_lcd_cmd_issuer;
    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] in_cmd;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] lcd_cmd;
    logic       lcd_cmd_valid;
    logic       lcd_busy;
    logic       lcd_done;
    logic [7:0] issued_cnt;
    logic       fin;

    int n_checks = 0;
    int n_fail   = 0;
    int strobe_cnt = 0;
    logic [3:0] exp_q[$];

    lcd_cmd_issuer #(.FIFO_DEPTH(8)) dut (
        .clk(clk), .reset(reset), .in_cmd(in_cmd), .in_valid(in_valid),
        .in_ready(in_ready), .lcd_cmd(lcd_cmd), .lcd_cmd_valid(lcd_cmd_valid),
        .lcd_busy(lcd_busy), .lcd_done(lcd_done), .issued_cnt(issued_cnt), .fin(fin)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every strobe must match the head of the expected queue.
    always @(negedge clk) begin
        if (!reset && lcd_cmd_valid) begin
            strobe_cnt++;
            check("strobe_not_busy", lcd_busy, 0);
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_issue: got cmd %0d expected no issue", lcd_cmd);
            end else begin
                check("issued_cmd", lcd_cmd, exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [3:0] cmd, input bit expect_issue);
        in_cmd   = cmd;
        in_valid = 1'b1;
        if (expect_issue) exp_q.push_back(cmd);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_strobes(input int n, input int budget, input string name);
        int k = 0;
        while (strobe_cnt < n && k < budget) begin
            tick();
            k++;
        end
        tick();
        check(name, strobe_cnt, n);
    endtask

    initial begin
        int saved;
        int n_filter;
        bit hit;
        reset = 1'b1; in_cmd = '0; in_valid = 1'b0; lcd_busy = 1'b1; lcd_done = 1'b0;
        repeat (3) tick();
        check("rst_lcd_cmd", lcd_cmd, 0);
        check("rst_valid", lcd_cmd_valid, 0);
        check("rst_issued_cnt", issued_cnt, 0);
        check("rst_fin", fin, 0);
        check("rst_in_ready", in_ready, 1);

        // Busy for 70 cycles: nothing may issue until it falls.
        reset = 1'b0;
        push(4'd5, 1'b1);
        repeat (69) tick();
        check("busy_hold_no_issue", strobe_cnt, 0);
        lcd_busy = 1'b0;
        wait_strobes(1, 20, "first_issue");
        check("issued_cnt_1", issued_cnt, 1);

        // Illegal command discarded, following one issued.
        push(4'd13, 1'b0);
        push(4'd1, 1'b1);
        wait_strobes(2, 20, "illegal_skip");
        check("issued_cnt_2", issued_cnt, 2);

        // Fill past depth while busy: ninth push dropped.
        lcd_busy = 1'b1;
        tick();
        for (int i = 0; i < 9; i++) begin
            logic [3:0] c;
            c = (i < 8) ? 4'(i + 1) : 4'd10;
            check("in_ready_fill", in_ready, (i < 8) ? 1 : 0);
            push(c, i < 8);
        end
        lcd_busy = 1'b0;
        wait_strobes(10, 100, "fifo_drain");
        check("issued_cnt_10", issued_cnt, 10);
        check("in_ready_empty", in_ready, 1);

        // Point is at x=4 here: three Rights reach x=7 when filtering.
`ifdef LCD_SHIFT_FILTER_EN
        n_filter = 3;
`else
        n_filter = 5;
`endif
        for (int i = 0; i < 5; i++) push(4'd4, i < n_filter);
        wait_strobes(10 + n_filter, 60, "shift_right_run");
        repeat (10) tick();
        check("shift_issued_cnt", issued_cnt, 10 + n_filter);

        // Reset in the middle of an issue strobe.
        lcd_busy = 1'b1;
        push(4'd6, 1'b0);
        push(4'd7, 1'b0);
        push(4'd8, 1'b0);
        lcd_busy = 1'b0;
        hit = 1'b0;
        for (int k = 0; k < 20 && !hit; k++) begin
            @(posedge clk);
            #1;
            hit = lcd_cmd_valid;
        end
        check("reached_issue", hit, 1);
        saved = strobe_cnt;
        reset = 1'b1;
        #1;
        check("reset_kills_valid", lcd_cmd_valid, 0);
        repeat (2) tick();
        reset = 1'b0;
        check("post_rst_issued_cnt", issued_cnt, 0);
        check("post_rst_lcd_cmd", lcd_cmd, 0);
        check("post_rst_in_ready", in_ready, 1);
        repeat (15) tick();
        check("fifo_flushed", strobe_cnt, saved);

        // Write then lcd_done 64 cycles later ends operation.
        push(4'd0, 1'b1);
        wait_strobes(saved + 1, 20, "write_issue");
        repeat (62) tick();
        check("fin_before_done", fin, 0);
        lcd_done = 1'b1;
        tick();
        lcd_done = 1'b0;
        check("fin_set", fin, 1);
        check("finish_in_ready", in_ready, 0);
        for (int i = 0; i < 5; i++) push(4'(i + 2), 1'b0);
        repeat (20) tick();
        check("finish_no_issue", strobe_cnt, saved + 1);
        check("finish_issued_cnt", issued_cnt, 1);
        check("fin_sticky", fin, 1);
        check("exp_q_drained", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected end before 200000");
        $fatal(1);
    end
endmodule
